// File: rtl/dm_lsu_mem.sv
// Byte/half/word data memory with valid/ready request port, fixed LAT-cycle response,
// alignment/range error flagging and a post-reset clear sequence.
module dm_lsu_mem #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned LAT    = 1,
   parameter int unsigned TRACE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_sign,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic [0:0] {CLEAR, RUN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_idx;
   logic              ready_nxt, busy_nxt;

   logic [31:0]       mem [DEPTH];

   logic              accept;
   logic              err;
   logic              wr_store;
   logic [ADDR_W-1:0] word_idx;
   logic [31:0]       old_word;
   logic [3:0]        lane_en;
   logic [31:0]       wrep;
   logic [31:0]       merged;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_data;
   logic [31:0]       rsp_data0;

   logic [LAT-1:0]    pipe_valid;
   logic [LAT-1:0]    pipe_err;
   logic [31:0]       pipe_data [LAT];

   // State register; ready/busy are registered copies of the next-state decode
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= CLEAR;
         clr_idx   <= '0;
         req_ready <= 1'b0;
         busy      <= 1'b1;
      end else begin
         state     <= state_nxt;
         req_ready <= ready_nxt;
         busy      <= busy_nxt;
         if (state == CLEAR) clr_idx <= clr_idx + ADDR_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == CLEAR && clr_idx == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
   end

   always_comb begin
      ready_nxt = 1'b0;
      busy_nxt  = 1'b1;
      if (state_nxt == RUN) begin
         ready_nxt = 1'b1;
         busy_nxt  = 1'b0;
      end
   end

   // Request decode: error check, lane enables and store merge
   always_comb begin
      accept   = req_valid && req_ready;
      word_idx = req_addr[ADDR_W+1:2];
      old_word = mem[word_idx];
      err      = ((req_addr >> (ADDR_W + 2)) != 32'd0);
      lane_en  = 4'b0000;
      wrep     = req_wdata;
      case (req_size)
         2'b00: begin
            lane_en = 4'b0001 << req_addr[1:0];
            wrep    = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            lane_en = req_addr[1] ? 4'b1100 : 4'b0011;
            wrep    = {2{req_wdata[15:0]}};
            if (req_addr[0]) err = 1'b1;
         end
         2'b10: begin
            lane_en = 4'b1111;
            if (req_addr[1:0] != 2'b00) err = 1'b1;
         end
         default: err = 1'b1;
      endcase
      merged = old_word;
      for (int unsigned l = 0; l < 4; l++) begin
         if (lane_en[l]) merged[8*l +: 8] = wrep[8*l +: 8];
      end
      wr_store = reset && accept && req_we && !err;
   end

   // Load extraction and extension from the word sampled at accept
   always_comb begin
      ld_byte = 8'(old_word >> {req_addr[1:0], 3'b000});
      ld_half = req_addr[1] ? old_word[31:16] : old_word[15:0];
      case (req_size)
         2'b00:   ld_data = req_sign ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
         2'b01:   ld_data = req_sign ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
         default: ld_data = old_word;
      endcase
      rsp_data0 = (err || req_we) ? 32'd0 : ld_data;
   end

   // Memory array: clear walk, then committed stores
   always_ff @(posedge clk) begin
      if (reset) begin
         if (state == CLEAR)  mem[clr_idx]  <= 32'd0;
         else if (wr_store)   mem[word_idx] <= merged;
      end
   end

   // Response pipeline; a low reset flushes everything in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         pipe_valid <= '0;
         pipe_err   <= '0;
         for (int unsigned i = 0; i < LAT; i++) pipe_data[i] <= 32'd0;
      end else begin
         pipe_valid[0] <= accept;
         pipe_err[0]   <= accept && err;
         pipe_data[0]  <= accept ? rsp_data0 : 32'd0;
         for (int unsigned i = 1; i < LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
      end
   end

   assign rsp_valid = pipe_valid[LAT-1];
   assign rsp_err   = pipe_err[LAT-1];
   assign rsp_rdata = pipe_data[LAT-1];

   generate
      if (TRACE == 1) begin : g_trace
         always_ff @(posedge clk) begin
            if (wr_store)
               $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged);
         end
      end
   endgenerate

endmodule

// File: tb/tb_dm_lsu_mem.sv
// Bench for dm_lsu_mem: two instances (LAT=2, LAT=3, ADDR_W=4) driven identically and
// scored every cycle against a byte-array reference model with per-instance response queues.
module tb_dm_lsu_mem;

   localparam int unsigned AW      = 4;
   localparam int unsigned NWORDS  = 1 << AW;
   localparam int unsigned NBYTES  = NWORDS * 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we, req_sign;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, req_pc;

   logic        rdy2, rv2, re2, bz2;
   logic [31:0] rd2;
   logic        rdy3, rv3, re3, bz3;
   logic [31:0] rd3;

   always #5 clk = ~clk;

   dm_lsu_mem #(.ADDR_W(AW), .LAT(2), .TRACE(1)) u_lat2 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
      .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_pc(req_pc), .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2), .busy(bz2));

   dm_lsu_mem #(.ADDR_W(AW), .LAT(3), .TRACE(0)) u_lat3 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
      .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_pc(req_pc), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3), .busy(bz3));

   typedef struct {
      int          due;
      logic [31:0] d;
      logic        e;
   } rsp_t;

   logic [7:0]  mb [NBYTES];
   rsp_t        q2[$], q3[$];
   logic [32:0] log2[$];
   int          edge_n  = 0;
   bit          run_m   = 0;
   int          clr_m   = 0;
   bit          started = 0;
   int          cnt3    = 0;
   int          total   = 0;
   int          bad     = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: one clock edge. A response is visible in the cycle after edge (accept+LAT-1).
   task automatic model_edge();
      int unsigned a;
      int          nb;
      logic [31:0] d;
      logic        e;
      edge_n++;
      if (!reset) begin
         started = 1;
         run_m   = 0;
         clr_m   = 0;
         q2.delete();
         q3.delete();
      end else if (!run_m) begin
         clr_m++;
         if (clr_m == NWORDS) begin
            run_m = 1;
            for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
         end
      end else if (req_valid) begin
         a  = req_addr;
         nb = 1 << req_size;
         e  = (req_size == 2'd3) || (a >= NBYTES) ||
              (req_size == 2'd1 && (a % 2) != 0) || (req_size == 2'd2 && (a % 4) != 0);
         d  = 32'd0;
         if (!e) begin
            if (req_we) begin
               for (int i = 0; i < nb; i++) mb[a + i] = 8'(req_wdata >> (8 * i));
            end else begin
               for (int i = 0; i < nb; i++) d = d | (32'(mb[a + i]) << (8 * i));
               if (req_sign && nb < 4 && d[8*nb-1]) d = d | (32'hFFFF_FFFF << (8 * nb));
            end
         end
         q2.push_back('{edge_n + 1, d, e});
         q3.push_back('{edge_n + 2, d, e});
      end
   endtask

   task automatic check_all();
      rsp_t r;
      logic ev;
      if (!started) return;
      chk("busy_l2", 32'(bz2), 32'(!run_m));
      chk("ready_l2", 32'(rdy2), 32'(run_m));
      chk("busy_l3", 32'(bz3), 32'(!run_m));
      chk("ready_l3", 32'(rdy3), 32'(run_m));
      ev = (q2.size() > 0 && q2[0].due == edge_n);
      chk("rsp_valid_l2", 32'(rv2), 32'(ev));
      if (ev) begin
         r = q2.pop_front();
         chk("rsp_rdata_l2", rd2, r.d);
         chk("rsp_err_l2", 32'(re2), 32'(r.e));
      end
      ev = (q3.size() > 0 && q3[0].due == edge_n);
      chk("rsp_valid_l3", 32'(rv3), 32'(ev));
      if (ev) begin
         r = q3.pop_front();
         chk("rsp_rdata_l3", rd3, r.d);
         chk("rsp_err_l3", 32'(re3), 32'(r.e));
      end
      if (rv2 === 1'b1) log2.push_back({re2, rd2});
      if (rv3 === 1'b1) cnt3++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_sign  = sign;
      req_addr  = addr;
      req_wdata = wdata;
      req_pc    = req_pc + 32'd4;
      tick();
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) tick();
   endtask

   function automatic logic [32:0] got(input int i);
      return (i < log2.size()) ? log2[i] : 33'h1_DEAD_DEAD;
   endfunction

   task automatic clear_run(input string tag);
      int n = 0;
      reset = 1'b1;
      while (bz2 === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk(tag, 32'(n), 32'(NWORDS));
   endtask

   initial begin
      logic [31:0] exp_b2b [6];
      int          r;
      exp_b2b = '{32'h0, 32'h1, 32'h80, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0; req_pc = 32'h0000_1000;

      // Reset, clear timing, first load
      repeat (3) tick();
      clear_run("clear_cycles");
      log2.delete();
      issue(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0);
      idle(3);
      chk("lw3c_count", 32'(log2.size()), 32'd1);
      chk("lw3c_data", got(0)[31:0], 32'h0);
      chk("lw3c_err", 32'(got(0)[32]), 32'd0);

      // Back-to-back store then extending loads
      log2.delete();
      issue(1'b1, 2'd2, 1'b0, 32'h8, 32'h80FF_7F01);
      issue(1'b0, 2'd0, 1'b1, 32'h8, 32'h0);
      issue(1'b0, 2'd0, 1'b0, 32'hB, 32'h0);
      issue(1'b0, 2'd1, 1'b1, 32'hA, 32'h0);
      issue(1'b0, 2'd1, 1'b0, 32'hA, 32'h0);
      issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
      idle(4);
      chk("b2b_count", 32'(log2.size()), 32'd6);
      for (int i = 0; i < 6; i++) chk($sformatf("b2b_%0d", i), got(i)[31:0], exp_b2b[i]);

      // Partial stores merge into one word
      log2.delete();
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
      issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA);
      issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      idle(4);
      chk("merge_lw10", got(3)[31:0], 32'hBEEF_AA44);

      // Error cases must not write and must flag
      log2.delete();
      issue(1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D);
      issue(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
      issue(1'b0, 2'd1, 1'b0, 32'h5, 32'h0);
      issue(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
      issue(1'b1, 2'd2, 1'b0, 32'(NBYTES), 32'hDEAD_BEEF);
      issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
      idle(4);
      for (int i = 1; i < 5; i++) begin
         chk($sformatf("err_flag_%0d", i), 32'(got(i)[32]), 32'd1);
         chk($sformatf("err_data_%0d", i), got(i)[31:0], 32'h0);
      end
      chk("err_word0_kept", got(5)[31:0], 32'hCAFE_F00D);

      // Reset one cycle after a load accept discards the response and reruns clear
      cnt3 = 0;
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      req_valid = 1'b0;
      reset = 1'b0;
      tick();
      clear_run("reclear_cycles");
      idle(4);
      chk("midflight_no_rsp", 32'(cnt3), 32'd0);
      log2.delete();
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
      idle(4);
      chk("reclear_lw10", got(0)[31:0], 32'h0);
      chk("reclear_lw8", got(1)[31:0], 32'h0);

      // Randomized traffic, occasional resets, scored by the model every cycle
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            req_valid = 1'b0;
            reset = 1'b0;
            tick();
            reset = 1'b1;
            continue;
         end
         r = $urandom_range(0, 9);
         req_valid = ($urandom_range(0, 3) != 0);
         req_we    = 1'($urandom_range(0, 1));
         req_sign  = 1'($urandom_range(0, 1));
         req_size  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         req_addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
         req_wdata = $urandom;
         req_pc    = req_pc + 32'd4;
         tick();
      end
      idle(24);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dm_lsu_mem.md
Name: dm_lsu_mem

Overview:
- Parametrised data memory for the single-cycle/pipelined CPU datapath. Replaces the flat word-only DM.
- Adds byte/half/word access with sign/zero extension, a valid/ready request port and a fixed, parametrised read latency.
- Adds alignment/range error flagging and a sequenced post-reset clear. Sits between the ALU/EX stage address path and the writeback mux.

Parameters:
- ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W words of 32 bits.
- LAT, 1, response latency in cycles, legal range 1..4.
- TRACE, 1, when 1 each committed store prints a trace line.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_sign  in  1  loads only: 1 sign-extend, 0 zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_pc  in  32  PC of the issuing instruction, used for trace only.
- rsp_valid  out  1  response pulse, LAT cycles after accept.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request was misaligned, out of range or had an illegal size.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset and clear sequence:
  - While reset==0 at a clock edge: state<=CLEAR, clear index<=0, pipeline flushed.
  - Outputs forced: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, busy=1.
  - After reset rises, CLEAR writes 0 to word[idx] each cycle, idx 0..DEPTH-1. This takes exactly DEPTH cycles. The block then enters RUN with busy=0 and req_ready=1.
  - reset low during CLEAR or RUN restarts CLEAR from idx 0. In-flight responses are discarded and never emitted.
- Handshake:
  - Accept occurs on an edge where req_valid && req_ready. In RUN, req_ready=1 every cycle, so up to one request per cycle.
  - No response backpressure. Each accepted request yields exactly one rsp_valid pulse exactly LAT cycles after its accept edge, in order.
- Error check, evaluated at accept:
  - err if req_size==11.
  - err if half with addr[0]!=0.
  - err if word with addr[1:0]!=0.
  - err if addr[31:ADDR_W+2]!=0.
  - An erroring request performs no write and responds with rsp_err=1, rsp_rdata=0.
- Store:
  - Word index = addr[ADDR_W+1:2].
  - Byte stores write lane addr[1:0] with wdata[7:0].
  - Half stores write lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Word stores write all 4 lanes. Other lanes are unchanged.
  - The write commits at the accept edge. The response carries rsp_rdata=0, rsp_err=0.
- Load:
  - The array word is sampled at the accept edge. A load accepted the cycle after a store to the same word sees the new data.
  - Extract byte at lane addr[1:0], or half at addr[1]*16.
  - Extend per req_sign. Word loads ignore req_sign.
  - Data passes through LAT-1 further register stages.
- Trace: if TRACE==1, each committed store prints "%d@%h: *%h <= %h" with $time, req_pc, word-aligned byte address {addr[31:2],2'b00} and the full merged 32-bit word after the write. Errored stores print nothing.
- Little-endian lane order: lane 0 = bits [7:0].

Test Plan:
- Reset low 3 cycles, then high, with ADDR_W=4 → busy=1 and req_ready=0 for exactly 16 cycles; then busy=0 and req_ready=1; a word load of addr 0x3C returns 0x00000000 with rsp_err=0.
- Back-to-back requests, LAT=2: sw 0x8 ← 0x80FF7F01, then lb 0x8, lbu 0xB, lh 0xA, lhu 0xA, lw 0x8 → responses 2 cycles after each accept, consecutive cycles: 0x00000001, 0x00000080, 0xFFFF80FF, 0x000080FF, 0x80FF7F01.
- Partial stores: sw 0x10 ← 0x11223344, then sb 0x11 ← 0xAA, then sh 0x12 ← 0xBEEF, then lw 0x10 → 0xBEEFAA44; trace shows merged words 0x1122AA44 then 0xBEEFAA44.
- Errors, each case: lw 0x6, lh 0x5, size 11, and sw to (DEPTH*4) with 0xDEADBEEF → rsp_err=1, rsp_rdata=0; a following lw of word 0 is unchanged; no trace line printed.
- Reset mid-flight, LAT=3: accept lw, assert reset low one cycle later → no rsp_valid ever for that load; full clear reruns from idx 0; previously stored data reads back 0.
